// File: rtl/mult_pkg.sv
// Shared types for the multiply sequencer: FSM encoding, accumulate op codes,
// operand payload.
package mult_pkg;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned RES_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ACC  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ACC_NONE = 2'b00,
        ACC_MADD = 2'b01,
        ACC_MSUB = 2'b10
    } acc_op_e;

    typedef struct packed {
        logic            sgn;
        logic [OP_W-1:0] op1;
        logic [OP_W-1:0] op2;
    } operands_t;

endpackage

// File: rtl/mult.sv
// Combinational 32x32 multiplier: signed mode multiplies magnitudes and
// negates when the operand signs differ.
module mult
    import mult_pkg::*;
(
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    input  logic             signed_i,
    output logic [RES_W-1:0] product_c
);

    logic             neg_a;
    logic             neg_b;
    logic [OP_W-1:0]  mag_a;
    logic [OP_W-1:0]  mag_b;
    logic [RES_W-1:0] mag_p;

    // Magnitude multiply, then restore the sign
    always_comb begin
        neg_a     = signed_i & a_i[OP_W-1];
        neg_b     = signed_i & b_i[OP_W-1];
        mag_a     = neg_a ? (~a_i + OP_W'(1)) : a_i;
        mag_b     = neg_b ? (~b_i + OP_W'(1)) : b_i;
        mag_p     = RES_W'(mag_a) * RES_W'(mag_b);
        product_c = (neg_a ^ neg_b) ? (~mag_p + RES_W'(1)) : mag_p;
    end

endmodule

// File: rtl/mult_ctrl.sv
// Multi-cycle sequencer for the MULT/MULTU multiplier between EX and HI/LO.
// Optional accumulate (MADD/MSUB) is enabled with MULT_CTRL_MADD_EN.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [OP_W-1:0]  op1_i,
    input  logic [OP_W-1:0]  op2_i,
    input  logic             flush_i,
    input  logic             ack_i,
`ifdef MULT_CTRL_MADD_EN
    input  logic [1:0]       acc_i,
    input  logic [RES_W-1:0] hilo_i,
`endif
    output logic             stall_o,
    output logic             busy_o,
    output logic             valid_o,
    output logic [RES_W-1:0] result_o
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    operands_t        opr_q;
    logic             accept;
    logic             valid_d;
    logic             load_res;
    logic [RES_W-1:0] res_d;
    logic [RES_W-1:0] product;
`ifdef MULT_CTRL_MADD_EN
    acc_op_e          acc_q;
`endif

    mult u_mult (
        .a_i       (opr_q.op1),
        .b_i       (opr_q.op2),
        .signed_i  (opr_q.sgn),
        .product_c (product)
    );

    // Next-state, counter and result-load decode; flush overrides everything
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        valid_d  = valid_o;
        load_res = 1'b0;
        res_d    = result_o;
        unique case (state_q)
            IDLE: begin
                accept = start_i;
            end
            CALC: begin
                if (cnt_q == '0) begin
                    load_res = 1'b1;
                    res_d    = product;
`ifdef MULT_CTRL_MADD_EN
                    state_d  = ACC;
`else
                    state_d  = DONE;
                    valid_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef MULT_CTRL_MADD_EN
            ACC: begin
                load_res = 1'b1;
                case (acc_q)
                    ACC_MADD: res_d = hilo_i + result_o;
                    ACC_MSUB: res_d = hilo_i - result_o;
                    default:  res_d = result_o;
                endcase
                state_d = DONE;
                valid_d = 1'b1;
            end
`endif
            DONE: begin
                if (ack_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    accept  = start_i;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
        if (accept) begin
            state_d = CALC;
            cnt_d   = CNT_W'(LATENCY - 1);
            valid_d = 1'b0;
        end
        if (flush_i) begin
            accept   = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
            valid_d  = 1'b0;
            load_res = 1'b0;
        end
    end

    // Stall covers the accept cycle and every cycle the result is pending
    assign stall_o = resetn & (accept | (state_q == CALC) | (state_q == ACC));

    // State, counter, operand capture and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opr_q    <= '0;
            valid_o  <= 1'b0;
            busy_o   <= 1'b0;
            result_o <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_o <= valid_d;
            busy_o  <= (state_d != IDLE);
            if (accept) begin
                opr_q.sgn <= signed_i;
                opr_q.op1 <= op1_i;
                opr_q.op2 <= op2_i;
            end
            if (load_res) begin
                result_o <= res_d;
            end
        end
    end

`ifdef MULT_CTRL_MADD_EN
    // Accumulate op is captured with the operands
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q <= ACC_NONE;
        end else if (accept) begin
            acc_q <= acc_op_e'(acc_i);
        end
    end
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: directed cases plus random traffic
// compared every cycle against a cycle-count model of the sequencer.
module tb_mult_ctrl;

    localparam int unsigned LAT = 2;
`ifdef MULT_CTRL_MADD_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic        flush_i = 1'b0;
    logic        ack_i = 1'b0;
    logic [1:0]  acc_r = 2'b00;
    logic [63:0] hilo_r = '0;
    logic        stall_o;
    logic        busy_o;
    logic        valid_o;
    logic [63:0] result_o;

    int checks = 0;
    int errors = 0;

    // Model state: stall cycles still owed after accept, pending result
    int          m_left  = 0;
    bit          m_valid = 1'b0;
    logic [63:0] m_prod  = '0;
    logic [63:0] m_res   = '0;
    logic [1:0]  m_acc   = 2'b00;

    mult_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .signed_i (signed_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .flush_i  (flush_i),
        .ack_i    (ack_i),
`ifdef MULT_CTRL_MADD_EN
        .acc_i    (acc_r),
        .hilo_i   (hilo_r),
`endif
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    function automatic logic [63:0] ref_final(input logic [63:0] p, input logic [1:0] acc, input logic [63:0] hilo);
        if (EXTRA == 0) return p;
        case (acc)
            2'b01:   return hilo + p;
            2'b10:   return hilo - p;
            default: return p;
        endcase
    endfunction

    // Per-cycle compare against the model, then advance the model over the next edge
    always @(negedge clk) begin
        bit idle;
        bit acc_now;
        if (!resetn) begin
            m_left  = 0;
            m_valid = 1'b0;
            chk("rst_stall", 64'(stall_o), 64'(0));
            chk("rst_busy", 64'(busy_o), 64'(0));
            chk("rst_valid", 64'(valid_o), 64'(0));
            chk("rst_result", result_o, 64'(0));
        end else begin
            idle    = (m_left == 0) && !m_valid;
            acc_now = !flush_i && start_i && (idle || (m_valid && ack_i));
            chk("stall", 64'(stall_o), 64'(acc_now || (m_left > 0)));
            chk("busy", 64'(busy_o), 64'((m_left > 0) || m_valid));
            chk("valid", 64'(valid_o), 64'(m_valid));
            if (m_valid) chk("result", result_o, m_res);
            if (flush_i) begin
                m_left  = 0;
                m_valid = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_res   = ref_final(m_prod, m_acc, hilo_r);
                end
            end else if (m_valid && ack_i) begin
                m_valid = 1'b0;
            end
            if (acc_now) begin
                m_left  = int'(LAT + EXTRA);
                m_prod  = ref_prod(op1_i, op2_i, signed_i);
                m_acc   = acc_r;
                m_valid = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic [1:0] acc);
        start_i  = 1'b1;
        signed_i = s;
        op1_i    = a;
        op2_i    = b;
        acc_r    = acc;
    endtask

    // Step over the accept edge, scramble inputs, wait for valid and check it
    task automatic finish_op(input string name, input logic [63:0] exp);
        int n;
        @(posedge clk); #1;
        start_i  = 1'b0;
        ack_i    = 1'b0;
        op1_i    = $urandom;
        op2_i    = $urandom;
        signed_i = ~signed_i;
        n = 0;
        while (!valid_o && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(LAT + EXTRA));
        chk({name, "_result"}, result_o, exp);
    endtask

    task automatic ack_one();
        ack_i = 1'b1;
        @(posedge clk); #1;
        ack_i = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #22 resetn = 1'b1;
        @(posedge clk); #1;

        // Unsigned and signed literals, including the most-negative square
        issue(32'hFFFF_FFFF, 32'd2, 1'b0, 2'b00);
        finish_op("unsigned", 64'h0000_0001_FFFF_FFFE);
        ack_one();
        issue(32'hFFFF_FFFE, 32'd3, 1'b1, 2'b00);
        finish_op("signed_neg", 64'hFFFF_FFFF_FFFF_FFFA);
        ack_one();
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, 2'b00);
        finish_op("signed_min", 64'h4000_0000_0000_0000);
        ack_one();

        // Flush in the first CALC cycle cancels the operation
        issue(32'd9, 32'd9, 1'b0, 2'b00);
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_stall", 64'(stall_o), 64'(0));
        chk("flush_busy", 64'(busy_o), 64'(0));
        chk("flush_valid", 64'(valid_o), 64'(0));
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back: ack and start together while DONE
        issue(32'd1000, 32'd1000, 1'b0, 2'b00);
        finish_op("b2b_first", 64'd1000000);
        ack_i = 1'b1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00);
        finish_op("b2b_second", 64'd1);
        ack_one();

        // Async reset in the middle of CALC clears outputs at once
        issue(32'd3, 32'd4, 1'b0, 2'b00);
        @(posedge clk); #1;
        start_i = 1'b0;
        #2 resetn = 1'b0;
        #1;
        chk("midrst_stall", 64'(stall_o), 64'(0));
        chk("midrst_busy", 64'(busy_o), 64'(0));
        chk("midrst_valid", 64'(valid_o), 64'(0));
        chk("midrst_result", result_o, 64'(0));
        @(negedge clk); #2 resetn = 1'b1;
        @(posedge clk); #1;
        issue(32'd6, 32'd7, 1'b0, 2'b00);
        finish_op("after_rst", 64'd42);
        ack_one();

`ifdef MULT_CTRL_MADD_EN
        hilo_r = '0;
        issue(32'd5, 32'd7, 1'b0, 2'b10);
        finish_op("msub", 64'hFFFF_FFFF_FFFF_FFDD);
        ack_one();
        hilo_r = {$urandom, $urandom};
`endif

        // Random traffic checked by the per-cycle model
        repeat (600) begin
            start_i  = ($urandom_range(0, 99) < 40);
            flush_i  = ($urandom_range(0, 99) < 6);
            ack_i    = ($urandom_range(0, 99) < 50);
            signed_i = 1'($urandom);
            op1_i    = pick();
            op2_i    = pick();
            acc_r    = 2'($urandom_range(0, 2));
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        flush_i = 1'b0;
        ack_i   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("final_idle_busy", 64'(busy_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
